// File: rtl/spi_master_driver.sv
`timescale 1ns/1ps
// spi_master_driver
// Turns a 10-bit parallel command into a serial SPI frame, one bit per clk.
// For read-data commands (opcode 11) it waits TURN cycles and then collects
// an 8-bit reply from MISO, MSB first.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset
//   start    frame request, accepted only in IDLE
//   cmd      [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data),
//            [7:0] payload
//   busy     high while a frame is in progress (state != IDLE)
//   done     one-cycle pulse in the END cycle
//   rd_data  byte captured on the most recent read-data frame
//   MOSI     serial data to slave (0 whenever SS_n is high)
//   SS_n     active-low slave select
//   MISO     serial data from slave
module spi_master_driver #(
    parameter int TURN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] cmd,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       MOSI,
    output logic       SS_n,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        SHIFT_OUT,
        TURN_WAIT,
        SHIFT_IN,
        END
    } state_t;

    localparam logic [3:0] TURN_LAST = 4'(TURN - 1);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    // Latched command; shifted left during SHIFT_OUT so bit 8 is always the
    // next bit to drive. The opcode is preserved separately in is_rd_reg.
    logic [9:0]  cmd_reg;
    logic        is_rd_reg;
    logic [7:0]  shift_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            cmd_reg   <= 10'd0;
            is_rd_reg <= 1'b0;
            shift_reg <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_data   <= 8'h00;
            MOSI      <= 1'b0;
            SS_n      <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cmd_reg   <= cmd;
                        is_rd_reg <= (cmd[9:8] == 2'b11);
                        SS_n      <= 1'b0;
                        MOSI      <= cmd[9];
                        busy      <= 1'b1;
                        state_reg <= SEL;
                    end
                end

                SEL: begin
                    // The select bit is repeated as the first command bit.
                    MOSI      <= cmd_reg[9];
                    cnt_reg   <= 4'd0;
                    state_reg <= SHIFT_OUT;
                end

                SHIFT_OUT: begin
                    if (cnt_reg == 4'd9) begin
                        cnt_reg <= 4'd0;
                        MOSI    <= 1'b0;
                        if (is_rd_reg) begin
                            state_reg <= TURN_WAIT;
                        end else begin
                            SS_n      <= 1'b1;
                            done      <= 1'b1;
                            state_reg <= END;
                        end
                    end else begin
                        MOSI    <= cmd_reg[8];
                        cmd_reg <= {cmd_reg[8:0], 1'b0};
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end

                TURN_WAIT: begin
                    if (cnt_reg == TURN_LAST) begin
                        cnt_reg   <= 4'd0;
                        state_reg <= SHIFT_IN;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end

                SHIFT_IN: begin
                    shift_reg <= {shift_reg[6:0], MISO};
                    if (cnt_reg == 4'd7) begin
                        // Last bit is folded in directly so rd_data is valid
                        // in the same cycle done is high.
                        rd_data   <= {shift_reg[6:0], MISO};
                        cnt_reg   <= 4'd0;
                        SS_n      <= 1'b1;
                        done      <= 1'b1;
                        state_reg <= END;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end

                END: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    SS_n      <= 1'b1;
                    MOSI      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_driver.sv
`timescale 1ns/1ps
// Directed testbench for spi_master_driver, including a small behavioural
// SPI RAM slave for the end-to-end write/read sequence.
module tb_spi_master_driver;

    localparam int TURN = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] cmd = 10'd0;
    logic       MISO = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       MOSI;
    logic       SS_n;

    spi_master_driver #(.TURN(TURN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cmd     (cmd),
        .busy    (busy),
        .done    (done),
        .rd_data (rd_data),
        .MOSI    (MOSI),
        .SS_n    (SS_n),
        .MISO    (MISO)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic       mosi_log [0:39];
    logic       ss_log   [0:39];
    logic       done_log [0:39];
    logic       busy_log [0:39];
    logic [7:0] rd_log   [0:39];
    logic [7:0] mem      [0:255];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a frame at edge k, then logs cycles k+1..k+ncyc. MISO is driven
    // from mb on the SHIFT_IN cycles of a read-data frame.
    task automatic do_frame(input logic [9:0] c, input logic [7:0] mb, input int ncyc,
                            input bit hold, input int chg_cyc, input logic [9:0] c2);
        cmd   = c;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int i = 1; i <= ncyc; i++) begin
            if (i == chg_cyc) cmd = c2;
            MISO = (i >= 12 + TURN && i <= 19 + TURN) ? mb[19 + TURN - i] : 1'b0;
            mosi_log[i] = MOSI;
            ss_log[i]   = SS_n;
            done_log[i] = done;
            busy_log[i] = busy;
            rd_log[i]   = rd_data;
            tick();
        end
        start = 1'b0;
        MISO  = 1'b0;
        $display("frame cmd=%h miso=%h cycles=%0d rd_data=%h", c, mb, ncyc, rd_data);
    endtask

    // Packs logged bits of cycles a..b, first cycle in the MSB position.
    function automatic logic [31:0] pack(input int sel, input int a, input int b);
        logic [31:0] v;
        logic        bv;
        v = 32'd0;
        for (int i = a; i <= b; i++) begin
            case (sel)
                0:       bv = mosi_log[i];
                1:       bv = ss_log[i];
                2:       bv = done_log[i];
                default: bv = busy_log[i];
            endcase
            v = {v[30:0], bv};
        end
        return v;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] seq [0:3];
        logic [9:0] rx;
        logic [7:0] wa;
        logic [7:0] ra;
        int         ndone;
        int         nc;
        bit         any_done;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_ss_n",    32'(SS_n),    32'd1);
        check("rst_mosi",    32'(MOSI),    32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        rst_n = 1'b1;
        tick();

        // Write-addr frame
        do_frame(10'h0AB, 8'h00, 14, 1'b0, 0, 10'h0);
        check("wa_mosi",      pack(0, 1, 11),  32'h0AB);
        check("wa_ss_n",      pack(1, 1, 14),  32'h0007);
        check("wa_done",      pack(2, 1, 14),  32'h0004);
        check("wa_busy",      pack(3, 1, 14),  32'h3FFC);
        check("wa_mosi_idle", pack(0, 12, 14), 32'h0);
        check("wa_rd_data",   32'(rd_data),    32'h00);

        // Read-data frame with MISO = 0xC5
        do_frame(10'h300, 8'hC5, 24, 1'b0, 0, 10'h0);
        check("rd_mosi",      pack(0, 1, 11),  32'h700);
        check("rd_mosi_tail", pack(0, 12, 24), 32'h0);
        check("rd_ss_n",      pack(1, 1, 24),  32'h000007);
        check("rd_done",      pack(2, 1, 24),  32'h000004);
        check("rd_busy",      pack(3, 1, 24),  32'hFFFFFC);
        check("rd_pre",       32'(rd_log[21]), 32'h00);
        check("rd_data_done", 32'(rd_log[22]), 32'hC5);

        // start held through frame and END, cmd changed mid-frame
        do_frame(10'h13C, 8'h00, 16, 1'b1, 5, 10'h0FF);
        check("hold_mosi", pack(0, 1, 11), 32'h13C);
        check("hold_ss_n", pack(1, 1, 16), 32'h0018);
        check("hold_done", pack(2, 1, 16), 32'h0010);
        wait_idle();
        check("hold_rd_data_kept", 32'(rd_data), 32'hC5);
        tick();

        // Reset in cycle k+6 of a write-data frame
        cmd   = 10'h1C3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("mid_ss_before", 32'(SS_n), 32'd0);
        rst_n = 1'b0;
        tick();
        check("mid_ss_n",    32'(SS_n),    32'd1);
        check("mid_mosi",    32'(MOSI),    32'd0);
        check("mid_busy",    32'(busy),    32'd0);
        check("mid_done",    32'(done),    32'd0);
        check("mid_rd_data", 32'(rd_data), 32'h00);
        rst_n    = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) any_done = 1'b1;
        end
        check("mid_no_done", 32'(any_done), 32'd0);
        do_frame(10'h0AB, 8'h00, 14, 1'b0, 0, 10'h0);
        check("post_rst_mosi", pack(0, 1, 11), 32'h0AB);
        check("post_rst_done", pack(2, 1, 14), 32'h0004);

        // Full RAM sequence through a behavioural slave
        seq[0] = 10'h012;
        seq[1] = 10'h15A;
        seq[2] = 10'h212;
        seq[3] = 10'h300;
        wa     = 8'h00;
        ra     = 8'h00;
        ndone  = 0;
        for (int f = 0; f < 4; f++) begin
            nc = (seq[f][9:8] == 2'b11) ? 24 : 14;
            do_frame(seq[f], mem[ra], nc, 1'b0, 0, 10'h0);
            rx = 10'd0;
            for (int j = 2; j <= 11; j++) rx = {rx[8:0], mosi_log[j]};
            case (rx[9:8])
                2'b00:   wa = rx[7:0];
                2'b01:   mem[wa] = rx[7:0];
                2'b10:   ra = rx[7:0];
                default: ;
            endcase
            for (int j = 1; j <= nc; j++) if (done_log[j]) ndone++;
            check("ram_busy_gap", 32'(busy_log[nc]), 32'd0);
        end
        check("ram_rd_data", 32'(rd_data), 32'h5A);
        check("ram_done_cnt", 32'(ndone),  32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
